fnd_scan_driver: RTL and testbench
==================================

# fnd_scan_driver

Four-digit multiplexed 7-segment (FND) display driver for a common-anode display with active-low segment and digit-enable pins. It generates its own digit-scan tick and a one-hot digit ring, and double-buffers a 16-bit hex value so a new value takes effect only at a frame boundary. It also applies leading-zero blanking, per-digit decimal points and per-digit blinking. It sits between the application logic that produces display values and the board's FND pins.

## Interface
- SCAN_DIV, 17: prescaler width; each digit is on for 2^SCAN_DIV clocks (762.9 Hz per digit at 100 MHz).
- BLINK_FRAMES, 6: blink phase toggles every 2^BLINK_FRAMES frames.

- clk  input  1  system clock, 100 MHz.
- reset_p  input  1  reset, asynchronous, active-high.
- value  input  16  hex digits; [3:0] is the rightmost digit (digit 0).
- dp_in  input  4  decimal point per digit, 1 = lit; latched together with value.
- load  input  1  single-cycle strobe; captures value and dp_in into the pending buffer.
- blank_lz  input  1  leading-zero blanking enable; sampled live.
- blink_mask  input  4  per-digit blink enable; sampled live.
- seg_n  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  output  1  decimal point, active-low.
- com_n  output  4  digit enables, active-low, one-hot-low.
- frame_tick  output  1  one-cycle pulse at each frame start.
- update_pending  output  1  high while a loaded value awaits its frame boundary.

## Operation
- **Prescaler**
  - SCAN_DIV-bit counter, free-running.
  - scan_tick is asserted in the cycle the counter equals all-ones; the counter then wraps to 0.
- **Digit ring**
  - Ring value resets to 0001.
  - On each scan_tick it rotates left: 0001, 0010, 0100, 1000, back to 0001.
  - com_n = ~ring at all times.
- **Frame start**: the scan_tick edge on which the ring goes 1000→0001. On that edge:
  - frame_tick is registered high for exactly one cycle.
  - If update_pending=1: shown ← pending and update_pending ← 0.
- **load**
  - pending_value ← value, pending_dp ← dp_in, update_pending ← 1.
  - Repeated loads before a frame start overwrite the buffer; the last load wins.
  - A load on the frame-start edge is not applied that frame. That edge promotes the old pending value, then the new load is captured and update_pending stays 1. If nothing was pending, only the new capture happens.
- **Hex decode**, seg_n gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- **Leading-zero blanking** (blank_lz=1)
  - Digit k (k=3..1) is blanked when shown digits k..3 are all zero.
  - Digit 0 is never blanked.
  - Blanked means seg_n=1111111 and dp_n=1.
- **Blink**
  - A BLINK_FRAMES-bit frame counter increments on each frame_tick.
  - blink_phase toggles when the counter wraps.
  - While blink_phase=1, digits with blink_mask[k]=1 are blanked.
  - com_n keeps scanning through blink and blanking.
- **Decimal point**: dp_n = ~shown_dp[k] for the active digit k, unless that digit is blanked.

## Timing
- **Registered outputs**: seg_n, dp_n, com_n and frame_tick are all registered. seg_n/dp_n change on the same edge as com_n, so there is no ghosting cycle.
- **Frame length**: 4·2^SCAN_DIV clocks; frame_tick period is the same.
- **Load-to-display latency**: from the load edge to the next frame start, between 1 and 4·2^SCAN_DIV clocks. A load on the frame-start edge waits one full additional frame.
- **Live inputs**: blank_lz and blink_mask affect the output from the next ring step.
- **Reset values**:
  - prescaler 0, ring 0001, com_n=1110
  - seg_n=1000000, dp_n=1
  - shown=0, pending=0, pending_dp=0, update_pending=0
  - frame_tick=0, blink counter 0, blink_phase 0
- **Reset mid-frame**: reset returns all outputs to their reset values immediately. A pending load is discarded.

## Test plan
All scenarios use SCAN_DIV=2 and BLINK_FRAMES=1.
- **Reset**: assert reset_p → com_n=1110, seg_n=1000000, dp_n=1, frame_tick=0, update_pending=0. Repeat with reset asserted mid-frame.
- **Scan order**: run 40 clocks after reset → com_n steps 1110, 1101, 1011, 0111, each held 4 clocks. frame_tick pulses once per 16 clocks, coincident with com_n returning to 1110.
- **Double buffering**: load value=16'h12AF, dp_in=0100 mid-frame.
  - update_pending=1 and the displayed digits are unchanged until the next frame_tick.
  - Next frame shows digit0=0001110, digit1=0001000, digit2=0100100 with dp_n=0, digit3=1111001.
- **Leading-zero blanking**: blank_lz=1.
  - value 16'h0005 → digits 3..1 seg_n=1111111, digit0=0010010.
  - value 16'h0000 → only digit0 is lit (1000000).
  - value 16'h0500 → digits 2..0 lit, digit3 blank.
- **Load collisions**:
  - load 16'h1111 then 16'h2222 in one frame → next frame shows 2222.
  - Pending 16'h3333, then load 16'h4444 on the frame-start edge → that frame shows 3333, update_pending stays 1, the following frame shows 4444.
- **Blink**: blink_mask=0001, value 16'h8888 → digit0 lit in frames 0-1, blanked in frames 2-3, repeating. com_n scan is unaffected and digits 1-3 always show 0000000.

Source files
------------

// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver
// ---------------
// Four-digit multiplexed 7-segment driver for a common-anode display.
// A free-running prescaler produces a scan tick that advances a one-hot
// digit ring. The value to show is double-buffered: a load lands in a
// pending buffer and is promoted to the displayed buffer only at a frame
// start, so a frame never mixes digits from two different values.
// Leading-zero blanking, per-digit decimal points and per-digit blinking
// are applied on top of the hex decode.
//
// Parameters
//   SCAN_DIV      prescaler width; each digit is lit for 2^SCAN_DIV clocks
//   BLINK_FRAMES  blink phase toggles every 2^BLINK_FRAMES frames
//
// Ports
//   clk             system clock
//   reset_p         asynchronous active-high reset
//   value[15:0]     four hex digits, [3:0] is digit 0 (rightmost)
//   dp_in[3:0]      decimal point per digit, 1 = lit
//   load            strobe: capture value/dp_in into the pending buffer
//   blank_lz        leading-zero blanking enable (live)
//   blink_mask[3:0] per-digit blink enable (live)
//   seg_n[6:0]      segments {g,f,e,d,c,b,a}, active-low
//   dp_n            decimal point, active-low
//   com_n[3:0]      digit enables, active-low, one-hot-low
//   frame_tick      one-cycle pulse at each frame start
//   update_pending  a loaded value is waiting for its frame boundary
module fnd_scan_driver #(
    parameter int SCAN_DIV     = 17,
    parameter int BLINK_FRAMES = 6
) (
    input  logic        clk,
    input  logic        reset_p,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    input  logic [3:0]  blink_mask,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [3:0]  com_n,
    output logic        frame_tick,
    output logic        update_pending
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    logic [SCAN_DIV-1:0]     presc_reg, presc_next;
    logic [3:0]              ring_reg, ring_next;
    logic [15:0]             pending_value_reg, pending_value_next;
    logic [3:0]              pending_dp_reg, pending_dp_next;
    logic                    update_pending_reg, update_pending_next;
    logic [15:0]             shown_value_reg, shown_value_next;
    logic [3:0]              shown_dp_reg, shown_dp_next;
    logic [BLINK_FRAMES-1:0] blink_cnt_reg, blink_cnt_next;
    logic                    blink_phase_reg, blink_phase_next;
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic                    frame_tick_reg;

    logic       scan_tick;
    logic       frame_start;
    logic [3:0] lz_blank;
    logic [3:0] digit_blank;
    logic [3:0] act_nib;
    logic       act_dp;
    logic       act_blank;

    assign scan_tick   = &presc_reg;
    // The ring leaves digit 3 on this tick, so the next cycle starts a frame.
    assign frame_start = scan_tick & ring_reg[3];

    always_comb begin
        presc_next          = presc_reg + SCAN_DIV'(1);
        ring_next           = scan_tick ? {ring_reg[2:0], ring_reg[3]} : ring_reg;

        // Promotion uses the pending buffer as it stood before this edge, so
        // a load that coincides with a frame start waits for the next frame.
        shown_value_next    = shown_value_reg;
        shown_dp_next       = shown_dp_reg;
        if (frame_start && update_pending_reg) begin
            shown_value_next = pending_value_reg;
            shown_dp_next    = pending_dp_reg;
        end

        pending_value_next  = pending_value_reg;
        pending_dp_next     = pending_dp_reg;
        update_pending_next = update_pending_reg;
        if (load) begin
            pending_value_next  = value;
            pending_dp_next     = dp_in;
            update_pending_next = 1'b1;
        end else if (frame_start) begin
            update_pending_next = 1'b0;
        end

        blink_cnt_next   = frame_start ? blink_cnt_reg + BLINK_FRAMES'(1) : blink_cnt_reg;
        blink_phase_next = (frame_start && (&blink_cnt_reg)) ? ~blink_phase_reg : blink_phase_reg;
    end

    // Blanking is evaluated against the state the display will hold after
    // this edge, so a freshly promoted value is blanked correctly on its
    // very first digit.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blank
            if (gi == 0) begin : g_lsd
                assign lz_blank[gi] = 1'b0;
            end else begin : g_upper
                assign lz_blank[gi] = blank_lz && (shown_value_next[15:4*gi] == '0);
            end
            assign digit_blank[gi] = lz_blank[gi] | (blink_phase_next & blink_mask[gi]);
        end
    endgenerate

    // Select the digit that becomes active after this edge.
    always_comb begin
        act_nib   = 4'h0;
        act_dp    = 1'b0;
        act_blank = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (ring_next[k]) begin
                act_nib   = shown_value_next[4*k +: 4];
                act_dp    = shown_dp_next[k];
                act_blank = digit_blank[k];
            end
        end
    end

    // Segment data only changes on a ring step, together with com_n, so the
    // newly enabled digit never shows its neighbour's pattern.
    always_comb begin
        seg_next = seg_reg;
        dp_next  = dp_reg;
        if (scan_tick) begin
            seg_next = act_blank ? SEG_BLANK : hex_to_seg(act_nib);
            dp_next  = act_blank | ~act_dp;
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            presc_reg          <= '0;
            ring_reg           <= 4'b0001;
            pending_value_reg  <= '0;
            pending_dp_reg     <= '0;
            update_pending_reg <= 1'b0;
            shown_value_reg    <= '0;
            shown_dp_reg       <= '0;
            blink_cnt_reg      <= '0;
            blink_phase_reg    <= 1'b0;
            seg_reg            <= SEG_ZERO;
            dp_reg             <= 1'b1;
            frame_tick_reg     <= 1'b0;
        end else begin
            presc_reg          <= presc_next;
            ring_reg           <= ring_next;
            pending_value_reg  <= pending_value_next;
            pending_dp_reg     <= pending_dp_next;
            update_pending_reg <= update_pending_next;
            shown_value_reg    <= shown_value_next;
            shown_dp_reg       <= shown_dp_next;
            blink_cnt_reg      <= blink_cnt_next;
            blink_phase_reg    <= blink_phase_next;
            seg_reg            <= seg_next;
            dp_reg             <= dp_next;
            frame_tick_reg     <= frame_start;
        end
    end

    assign seg_n          = seg_reg;
    assign dp_n           = dp_reg;
    assign com_n          = ~ring_reg;
    assign frame_tick     = frame_tick_reg;
    assign update_pending = update_pending_reg;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Testbench for fnd_scan_driver with SCAN_DIV=2, BLINK_FRAMES=1
// (4 clocks per digit, 16 clocks per frame, blink phase every 2 frames).
// Every cycle the outputs are compared with a reference model that works
// from the cycle count since reset; table vectors and hand sequences add
// targeted checks on top.
module tb_fnd_scan_driver;

    localparam int SD    = 2;
    localparam int BF    = 1;
    localparam int STEP  = 1 << SD;
    localparam int FRAME = 4 * STEP;

    logic        clk = 1'b0;
    logic        reset_p = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [3:0]  blink_mask = '0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  com_n;
    logic        frame_tick;
    logic        update_pending;

    fnd_scan_driver #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk            (clk),
        .reset_p        (reset_p),
        .value          (value),
        .dp_in          (dp_in),
        .load           (load),
        .blank_lz       (blank_lz),
        .blink_mask     (blink_mask),
        .seg_n          (seg_n),
        .dp_n           (dp_n),
        .com_n          (com_n),
        .frame_tick     (frame_tick),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    int          n;
    logic [15:0] m_shown, m_pend;
    logic [3:0]  m_shown_dp, m_pend_dp;
    logic        m_upd, m_ftick, m_dp;
    logic [6:0]  m_seg;
    logic [6:0]  seg_tab [16];

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp;
        logic            lz;
        logic [3:0][6:0] seg_e;
        logic [3:0]      dpn_e;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        n = 0;
        m_shown = '0; m_pend = '0; m_shown_dp = '0; m_pend_dp = '0;
        m_upd = 1'b0; m_ftick = 1'b0; m_seg = 7'b1000000; m_dp = 1'b1;
    endtask

    // One rising edge: frame boundary promotion, then load capture, then
    // the digit refresh if this edge moves to a new digit slot.
    task automatic model_edge();
        int   k;
        int   f;
        logic phase;
        logic blank;
        logic [3:0] nib;
        n++;
        m_ftick = (n % FRAME == 0);
        if (m_ftick && m_upd) begin
            m_shown = m_pend; m_shown_dp = m_pend_dp; m_upd = 1'b0;
        end
        if (load) begin
            m_pend = value; m_pend_dp = dp_in; m_upd = 1'b1;
        end
        if (n % STEP == 0) begin
            k     = (n / STEP) % 4;
            f     = n / FRAME;
            phase = ((f >> BF) & 1) != 0;
            nib   = m_shown[4*k +: 4];
            blank = (blank_lz && k > 0 && (m_shown >> (4*k)) == 16'h0) || (phase && blink_mask[k]);
            m_seg = blank ? 7'h7f : seg_tab[nib];
            m_dp  = blank ? 1'b1 : ~m_shown_dp[k];
        end
    endtask

    task automatic check_model();
        logic [3:0] ec;
        ec = ~(4'b0001 << ((n / STEP) % 4));
        chk("model", 32'({com_n, seg_n, dp_n, frame_tick, update_pending}),
                     32'({ec, m_seg, m_dp, m_ftick, m_upd}));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    // Entered at a negedge; asserts reset between edges and checks the
    // asynchronous response before the next clock edge.
    task automatic do_reset();
        #2;
        reset_p = 1'b1;
        load    = 1'b0;
        #1;
        chk("rst_com_n", 32'(com_n), 32'(4'b1110));
        chk("rst_seg_n", 32'(seg_n), 32'(7'b1000000));
        chk("rst_dp_n", 32'(dp_n), 32'(1'b1));
        chk("rst_frame_tick", 32'(frame_tick), 32'(1'b0));
        chk("rst_update_pending", 32'(update_pending), 32'(1'b0));
        @(negedge clk);
        reset_p = 1'b0;
        model_reset();
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ft_cnt;
        logic [6:0] exp_seg;

        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;

        // {value, dp_in, blank_lz, seg for digits {3,2,1,0}, dp_n for digits}
        tbl[0] = '{16'h12AF, 4'b0100, 1'b0, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1011};
        tbl[1] = '{16'h0005, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}, 4'b1111};
        tbl[2] = '{16'h0000, 4'b0000, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
        tbl[3] = '{16'h0500, 4'b1000, 1'b1, {7'b1111111, 7'b0010010, 7'b1000000, 7'b1000000}, 4'b1111};
        tbl[4] = '{16'h8888, 4'b1111, 1'b0, {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000}, 4'b0000};
        tbl[5] = '{16'h0C0D, 4'b0010, 1'b1, {7'b1111111, 7'b1000110, 7'b1000000, 7'b0100001}, 4'b1101};
        tbl[6] = '{16'h3467, 4'b0000, 1'b0, {7'b0110000, 7'b0011001, 7'b0000010, 7'b1111000}, 4'b1111};
        tbl[7] = '{16'h9E00, 4'b0001, 1'b1, {7'b0010000, 7'b0000110, 7'b1000000, 7'b1000000}, 4'b1110};
        tbl[8] = '{16'hB000, 4'b0001, 1'b0, {7'b0000011, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1110};

        @(negedge clk);
        do_reset();

        // Scan order over 40 clocks
        ft_cnt = 0;
        repeat (40) begin
            tick();
            if (frame_tick) begin
                ft_cnt++;
                chk("frame_tick_com", 32'(com_n), 32'(4'b1110));
            end
        end
        chk("frame_tick_count", 32'(ft_cnt), 32'(2));
        $display("scan order: 40 clocks, %0d frame ticks", ft_cnt);

        // Reset mid-frame discards a pending load
        value = 16'hABCD; dp_in = 4'b1111; load = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        do_reset();
        repeat (16) tick();
        chk("discarded_load_seg", 32'(seg_n), 32'(7'b1000000));
        $display("mid-frame reset: pending load discarded");

        // Table-driven load vectors
        for (int v = 0; v < 9; v++) begin
            do_reset();
            blank_lz = tbl[v].lz;
            blink_mask = 4'b0000;
            repeat (5) tick();
            value = tbl[v].value; dp_in = tbl[v].dp; load = 1'b1;
            tick();
            load = 1'b0;
            chk("pending_set", 32'(update_pending), 32'(1'b1));
            while (n < FRAME - 1) tick();
            exp_seg = tbl[v].lz ? 7'b1111111 : 7'b1000000;
            chk("old_value_held", 32'(seg_n), 32'(exp_seg));
            while (n < 2 * FRAME) begin
                tick();
                if (n % STEP == 0 && n < 2 * FRAME) begin
                    chk("table_seg", 32'(seg_n), 32'(tbl[v].seg_e[(n / STEP) % 4]));
                    chk("table_dp", 32'(dp_n), 32'(tbl[v].dpn_e[(n / STEP) % 4]));
                end
            end
            $display("vector %0d: value=%h dp=%b lz=%b", v, tbl[v].value, tbl[v].dp, tbl[v].lz);
        end
        blank_lz = 1'b0;

        // Two loads in one frame: last wins
        do_reset();
        value = 16'h1111; load = 1'b1; tick(); load = 1'b0;
        repeat (3) tick();
        value = 16'h2222; load = 1'b1; tick(); load = 1'b0;
        while (n < FRAME) tick();
        chk("last_load_wins", 32'(seg_n), 32'(7'b0100100));
        $display("collision: 1111 then 2222 -> 2222");

        // Load on the frame-start edge
        do_reset();
        repeat (4) tick();
        value = 16'h3333; load = 1'b1; tick(); load = 1'b0;
        while (n < FRAME - 1) tick();
        value = 16'h4444; load = 1'b1;
        tick();
        load = 1'b0;
        chk("edge_load_old_shown", 32'(seg_n), 32'(7'b0110000));
        chk("edge_load_pending", 32'(update_pending), 32'(1'b1));
        while (n < 2 * FRAME) tick();
        chk("edge_load_new_shown", 32'(seg_n), 32'(7'b0011001));
        chk("edge_load_cleared", 32'(update_pending), 32'(1'b0));
        $display("collision: 3333 pending, 4444 on frame edge -> 3333 then 4444");

        // Blink on digit 0
        do_reset();
        blink_mask = 4'b0001;
        value = 16'h8888; dp_in = 4'b0000; load = 1'b1; tick(); load = 1'b0;
        while (n < 6 * FRAME + 2 * STEP) begin
            tick();
            if (n >= FRAME && n % FRAME == 0) begin
                exp_seg = (((n / FRAME) / 2) % 2 == 1) ? 7'b1111111 : 7'b0000000;
                chk("blink_digit0", 32'(seg_n), 32'(exp_seg));
            end
            if (n >= FRAME && n % FRAME == STEP)
                chk("blink_digit1", 32'(seg_n), 32'(7'b0000000));
        end
        blink_mask = 4'b0000;
        $display("blink: digit0 toggles every 2 frames");

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            load  = ($urandom_range(0, 7) == 0);
            value = 16'($urandom);
            dp_in = 4'($urandom);
            if ($urandom_range(0, 31) == 0) blank_lz = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
            if (i == 400) do_reset();
            tick();
        end
        load = 1'b0;
        $display("random: 800 cycles against model");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
